// File: rtl/turn_scheduler_pkg.sv
// Shared game definitions: phase encoding, map geometry, unit indices and
// the linear tile helper used by the turn scheduler and the VGA side.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SELECTED   = 3'd1,
    ATTACK_TGT = 3'd2,
    ANIM       = 3'd3,
    ENEMY      = 3'd4,
    ROUND_END  = 3'd5,
    GAME_OVER  = 3'd6
  } phase_e;

  localparam int MAP_W  = 20;
  localparam int MAP_H  = 15;
  localparam int KNIGHT = 0;
  localparam int WIZARD = 1;

  // Row-major tile number y*MAP_W+x; the largest tile (19,14) is 299.
  function automatic logic [8:0] tile_index(input logic [4:0] x, input logic [4:0] y);
    return ({4'd0, y} * 9'(MAP_W)) + {4'd0, x};
  endfunction

endpackage

// File: rtl/turn_scheduler_if.sv
// Bundle between the joystick/unit logic and the turn scheduler.
// The scheduler connects through the slave modport, its driver through master.
interface turn_scheduler_if #(
  parameter int NUM_UNITS = 2
) ();

  localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  logic                    click_pulse;
  logic                    down_click_pulse;
  logic [4:0]              sel_x;
  logic [4:0]              sel_y;
  logic [10*NUM_UNITS-1:0] unit_xy;
  logic [NUM_UNITS-1:0]    unit_alive;
  logic                    anim_done;
  logic                    enemy_done;

  logic [UW-1:0]           active_unit;
  logic [8:0]              action_pos;
  logic [2:0]              phase;
  logic                    move_req;
  logic                    attack_req;
  logic [4:0]              tgt_x;
  logic [4:0]              tgt_y;
  logic                    enemy_go;
  logic                    reject;
  logic [NUM_UNITS-1:0]    acted;
  logic [7:0]              round_cnt;
  logic                    timeout_flag;

  modport master (
    output click_pulse, down_click_pulse, sel_x, sel_y, unit_xy, unit_alive,
           anim_done, enemy_done,
    input  active_unit, action_pos, phase, move_req, attack_req, tgt_x, tgt_y,
           enemy_go, reject, acted, round_cnt, timeout_flag
  );

  modport slave (
    input  click_pulse, down_click_pulse, sel_x, sel_y, unit_xy, unit_alive,
           anim_done, enemy_done,
    output active_unit, action_pos, phase, move_req, attack_req, tgt_x, tgt_y,
           enemy_go, reject, acted, round_cnt, timeout_flag
  );

endinterface

// File: rtl/turn_scheduler_tile_dist.sv
// Manhattan distance between two map tiles plus a same-tile flag.
module tile_dist (
  input  logic [4:0] ax_i,
  input  logic [4:0] ay_i,
  input  logic [4:0] bx_i,
  input  logic [4:0] by_i,
  output logic [5:0] dist_o,
  output logic       eq_o
);

  logic [4:0] dx;
  logic [4:0] dy;

  // Absolute differences per axis, summed without overflow in 6 bits.
  always_comb begin
    dx     = (ax_i >= bx_i) ? (ax_i - bx_i) : (bx_i - ax_i);
    dy     = (ay_i >= by_i) ? (ay_i - by_i) : (by_i - ay_i);
    dist_o = {1'b0, dx} + {1'b0, dy};
    eq_o   = (ax_i == bx_i) && (ay_i == by_i);
  end

endmodule

// File: rtl/turn_scheduler.sv
// Player/enemy round sequencer for the 20x15 tactics map.
// Optional macro TURN_SKIP_EN: a down-click in IDLE off any eligible unit
// ends the player phase early and hands over to the enemy.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int NUM_UNITS    = 2,
  parameter int MOVE_RANGE   = 3,
  parameter int ATTACK_RANGE = 1,
  parameter int ANIM_TIMEOUT = 4095
) (
  input  logic             clk,
  input  logic             rst,
  turn_scheduler_if.slave  bus
);

  localparam int              UW       = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int              TW       = $clog2(ANIM_TIMEOUT + 1);
  localparam logic [5:0]      MOVE_LIM = 6'(MOVE_RANGE);
  localparam logic [5:0]      ATK_LIM  = 6'(ATTACK_RANGE);
  localparam logic [TW-1:0]   TMO      = TW'(ANIM_TIMEOUT);

  phase_e               phase_q;
  logic [UW-1:0]        active_q;
  logic [8:0]           action_pos_q;
  logic                 move_req_q, attack_req_q, enemy_go_q, reject_q, timeout_q;
  logic [4:0]           tgt_x_q, tgt_y_q;
  logic [NUM_UNITS-1:0] acted_q;
  logic [7:0]           round_q;
  logic [TW-1:0]        timer_q;

  logic [4:0]           ux [NUM_UNITS];
  logic [4:0]           uy [NUM_UNITS];
  logic                 hit_d;
  logic [UW-1:0]        hit_idx_d;
  logic                 occupied_d;
  logic [5:0]           dist_d;
  logic                 same_tile_d;
  logic [NUM_UNITS-1:0] acted_done_d;
  logic                 all_done_d;
  logic                 anim_tmo_d;

  // Unpack the per-unit {y,x} fields into coordinate arrays.
  always_comb begin
    for (int k = 0; k < NUM_UNITS; k++) begin
      ux[k] = bus.unit_xy[10*k +: 5];
      uy[k] = bus.unit_xy[10*k+5 +: 5];
    end
  end

  tile_dist u_dist (
    .ax_i   (bus.sel_x),
    .ay_i   (bus.sel_y),
    .bx_i   (ux[active_q]),
    .by_i   (uy[active_q]),
    .dist_o (dist_d),
    .eq_o   (same_tile_d)
  );

  // Cursor hit test (lowest index wins), occupancy by other units, round-done test.
  always_comb begin
    hit_d      = 1'b0;
    hit_idx_d  = '0;
    occupied_d = 1'b0;
    for (int k = NUM_UNITS - 1; k >= 0; k--) begin
      if (bus.unit_alive[k] && !acted_q[k] && ux[k] == bus.sel_x && uy[k] == bus.sel_y) begin
        hit_d     = 1'b1;
        hit_idx_d = UW'(k);
      end
      if (bus.unit_alive[k] && UW'(k) != active_q && ux[k] == bus.sel_x && uy[k] == bus.sel_y)
        occupied_d = 1'b1;
    end
    acted_done_d = acted_q | (NUM_UNITS'(1) << active_q);
    all_done_d   = &(acted_done_d | ~bus.unit_alive);
    anim_tmo_d   = (timer_q + TW'(1)) == TMO;
  end

  // Round state machine; every request output is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q      <= IDLE;
      active_q     <= '0;
      action_pos_q <= '0;
      move_req_q   <= 1'b0;
      attack_req_q <= 1'b0;
      enemy_go_q   <= 1'b0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      tgt_x_q      <= '0;
      tgt_y_q      <= '0;
      acted_q      <= '0;
      round_q      <= '0;
      timer_q      <= '0;
    end else begin
      move_req_q   <= 1'b0;
      attack_req_q <= 1'b0;
      enemy_go_q   <= 1'b0;
      reject_q     <= 1'b0;
      if (phase_q != ENEMY && phase_q != GAME_OVER && bus.unit_alive == '0) begin
        phase_q <= GAME_OVER;
        timer_q <= '0;
      end else begin
        case (phase_q)
          IDLE: begin
            if (bus.click_pulse && hit_d) begin
              phase_q      <= SELECTED;
              active_q     <= hit_idx_d;
              action_pos_q <= tile_index(ux[hit_idx_d], uy[hit_idx_d]);
            end
`ifdef TURN_SKIP_EN
            else if (!bus.click_pulse && bus.down_click_pulse && !hit_d) begin
              phase_q    <= ENEMY;
              enemy_go_q <= 1'b1;
            end
`endif
          end
          SELECTED: begin
            if (!bus.unit_alive[active_q]) begin
              phase_q <= IDLE;
            end else if (bus.click_pulse) begin
              phase_q <= ATTACK_TGT;
            end else if (bus.down_click_pulse) begin
              if (!same_tile_d && dist_d <= MOVE_LIM && !occupied_d) begin
                tgt_x_q    <= bus.sel_x;
                tgt_y_q    <= bus.sel_y;
                move_req_q <= 1'b1;
                timer_q    <= '0;
                phase_q    <= ANIM;
              end else begin
                reject_q <= 1'b1;
              end
            end
          end
          ATTACK_TGT: begin
            if (!bus.unit_alive[active_q]) begin
              phase_q <= IDLE;
            end else if (bus.click_pulse) begin
              phase_q <= SELECTED;
            end else if (bus.down_click_pulse) begin
              if (!same_tile_d && dist_d <= ATK_LIM) begin
                tgt_x_q      <= bus.sel_x;
                tgt_y_q      <= bus.sel_y;
                attack_req_q <= 1'b1;
                timer_q      <= '0;
                phase_q      <= ANIM;
              end else begin
                reject_q <= 1'b1;
              end
            end
          end
          ANIM: begin
            if (bus.anim_done || anim_tmo_d) begin
              if (!bus.anim_done)
                timeout_q <= 1'b1;
              acted_q <= acted_done_d;
              timer_q <= '0;
              if (all_done_d) begin
                phase_q    <= ENEMY;
                enemy_go_q <= 1'b1;
              end else begin
                phase_q <= IDLE;
              end
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
          ENEMY: begin
            if (bus.enemy_done)
              phase_q <= ROUND_END;
          end
          ROUND_END: begin
            if (round_q != 8'hFF)
              round_q <= round_q + 8'd1;
            acted_q <= '0;
            phase_q <= IDLE;
          end
          GAME_OVER: phase_q <= GAME_OVER;
          default:   phase_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.phase        = phase_q;
  assign bus.active_unit  = active_q;
  assign bus.action_pos   = action_pos_q;
  assign bus.move_req     = move_req_q;
  assign bus.attack_req   = attack_req_q;
  assign bus.enemy_go     = enemy_go_q;
  assign bus.reject       = reject_q;
  assign bus.timeout_flag = timeout_q;
  assign bus.tgt_x        = tgt_x_q;
  assign bus.tgt_y        = tgt_y_q;
  assign bus.acted        = acted_q;
  assign bus.round_cnt    = round_q;

endmodule

// File: doc/turn_scheduler.md
Name: turn_scheduler

Overview:
Sequences one game round on the 20x15 tactics map:
- Player picks each allied unit in turn with the joystick cursor, then commits a move or an attack.
- Block waits for the unit's animation, then hands control to the enemy phase and advances the round counter.
- Sits between the joystick pulse logic (debounced click and down-click) and the unit/VGA logic. Drives action_pos and per-unit request pulses.

Parameters:
- NUM_UNITS, 2, number of player-controlled units (index 0 = knight, 1 = wizard).
- MAP_W, 20, map width in tiles.
- MAP_H, 15, map height in tiles.
- MOVE_RANGE, 3, maximum Manhattan distance for a move.
- ATTACK_RANGE, 1, maximum Manhattan distance for an attack.
- ANIM_TIMEOUT, 4095, cycles to wait for anim_done before forcing completion.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- click_pulse  in  1  one-cycle centre-click pulse.
- down_click_pulse  in  1  one-cycle down-click (commit) pulse.
- sel_x  in  5  cursor column, 0..19.
- sel_y  in  5  cursor row, 0..14.
- unit_xy  in  10*NUM_UNITS  packed {y[4:0],x[4:0]} per unit.
- unit_alive  in  NUM_UNITS  alive mask.
- anim_done  in  1  one-cycle pulse: current unit animation finished.
- enemy_done  in  1  one-cycle pulse: enemy phase finished.
- active_unit  out  1 (clog2 NUM_UNITS)  index of the unit being commanded.
- action_pos  out  9  linear tile of the active unit = y*20+x.
- phase  out  3  current FSM state.
- move_req  out  1  one-cycle pulse; destination is on tgt_x/tgt_y.
- attack_req  out  1  one-cycle pulse; target is on tgt_x/tgt_y.
- tgt_x  out  5  latched target column.
- tgt_y  out  5  latched target row.
- enemy_go  out  1  one-cycle pulse on entry to ENEMY.
- reject  out  1  one-cycle pulse on an illegal commit.
- acted  out  NUM_UNITS  units that have acted this round.
- round_cnt  out  8  completed rounds, saturates at 255.
- timeout_flag  out  1  sticky; set when an anim timeout fires.

Behaviour:
- Reset values: phase=IDLE; every other output and the timer = 0.
- All state updates on posedge clk. Request pulses are registered: they appear 1 cycle after the accepting pulse and last exactly 1 cycle.
- IDLE:
  - click_pulse with (sel_x,sel_y) equal to an alive, not-acted unit k -> SELECTED. Latch active_unit=k; action_pos = y_k*20+x_k.
  - If several units match, the lowest index wins. Any other click is ignored.
- SELECTED:
  - click_pulse -> ATTACK_TGT.
  - down_click_pulse with dist<=MOVE_RANGE and the cursor tile not occupied by another alive unit and dist!=0 -> latch tgt, pulse move_req, go to ANIM.
  - Illegal commit -> reject pulse, stay in SELECTED.
- ATTACK_TGT:
  - click_pulse -> SELECTED.
  - down_click_pulse with 1<=dist<=ATTACK_RANGE -> latch tgt, pulse attack_req, go to ANIM.
  - Otherwise reject pulse, stay.
- Same-cycle click_pulse and down_click_pulse: click_pulse wins; the down-click is dropped.
- dist = |sel_x-x_k| + |sel_y-y_k|, computed unsigned at 6 bits.
- ANIM:
  - Timer increments each cycle.
  - Exit on anim_done, or when the timer reaches ANIM_TIMEOUT (also sets timeout_flag).
  - On exit: set acted[k], clear the timer. If (acted|~unit_alive) is all ones -> ENEMY, else IDLE.
- ENEMY:
  - enemy_go pulses on the first cycle only.
  - Wait for enemy_done -> ROUND_END. anim_done is ignored here.
- ROUND_END:
  - Lasts a single cycle.
  - round_cnt += 1, saturating at 255. Clear acted. Go to IDLE.
- Active unit dies (alive[k] falls) in SELECTED/ATTACK_TGT -> IDLE with acted[k] unchanged. Death during ANIM does not abort it.
- unit_alive==0 in any state except ENEMY -> GAME_OVER. GAME_OVER is sticky until rst; all pulses held at 0.
- rst asserted mid-operation: immediate return to reset values. Pending pulses are dropped.

Optional Feature:
- Macro TURN_SKIP_EN.
- Defined: in IDLE, down_click_pulse while the cursor is not on an eligible unit ends the player phase. Next state is ENEMY; acted is left as is.
- Undefined: that pulse is ignored.

Decomposition:
- Shared package game_pkg holds:
  - phase encoding: IDLE=0, SELECTED=1, ATTACK_TGT=2, ANIM=3, ENEMY=4, ROUND_END=5, GAME_OVER=6;
  - MAP_W and MAP_H;
  - the unit index constants KNIGHT=0 and WIZARD=1.
- One sub-module, tile_dist: purely combinational. Takes two (x,y) pairs and outputs the 6-bit Manhattan distance plus an equal flag. It is instantiated for the range checks.

Test Plan:
- Knight at (5,6): click at (5,6), move cursor to (7,7), down-click -> move_req 1 cycle later, tgt=(7,7), action_pos=125, phase=ANIM.
- Same setup, cursor at (9,6) (dist 4) -> reject pulse, phase stays SELECTED, no move_req.
- Knight acted; select wizard at (7,8), click, cursor at (8,8), down-click, then anim_done -> attack_req, then enemy_go. enemy_done -> round_cnt=1, acted=00, phase=IDLE.
- Hold anim_done low in ANIM for ANIM_TIMEOUT cycles -> forced exit, timeout_flag=1, acted[k]=1.
- Same-cycle click and down-click in SELECTED -> ATTACK_TGT, no move_req. Drop unit_alive to 00 -> GAME_OVER, held until rst.
- With TURN_SKIP_EN: down-click in IDLE on an empty tile -> enemy_go next cycle. Without it -> phase stays IDLE.
